// File: rtl/debnc_evt_arb_if.sv
// Event handshake bundle between the debounce arbiter and its consumer.
//   evt_valid  arbiter -> consumer  an event is being presented
//   evt_ready  consumer -> arbiter  consumer takes the presented event
//   evt_ch     arbiter -> consumer  channel the event belongs to
//   evt_rise   arbiter -> consumer  1 = rising edge, 0 = falling edge
interface debnc_evt_arb_if #(
   parameter int N_CH = 4
) ();
   localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic           evt_valid;
   logic           evt_ready;
   logic [CHW-1:0] evt_ch;
   logic           evt_rise;

   modport master (output evt_valid, evt_ch, evt_rise, input evt_ready);
   modport slave  (input evt_valid, evt_ch, evt_rise, output evt_ready);
endinterface

// File: rtl/debnc_evt_arb.sv
// Multi-channel switch debouncer with a round-robin edge-event arbiter.
// Each raw switch is synchronized, then accepted only after its new level has
// persisted for N_TICKS ticks of a shared TICK_M-cycle timebase. Accepted
// edges become pending events that are presented one at a time on a
// valid/ready handshake; an edge that hits an already-pending bit sets a
// sticky overrun flag.
//
// Build option: define DEBNC_FALL_EVT_EN to also report falling edges. Without
// it only rising edges are reported and evt_rise is tied to 1; the debounced
// levels behave identically in both builds.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   sw       raw asynchronous switch levels [N_CH]
//   db       debounced levels [N_CH]
//   ovr      sticky per-channel overrun flags [N_CH]
//   clr_ovr  clears all ovr bits
//   evt      event handshake (master side)
//
// Output FSM:
//   state | meaning
//   IDLE  | nothing presented; picks the next pending event
//   HOLD  | event presented on evt, waiting for evt_ready
module debnc_evt_arb #(
   parameter int N_CH    = 4,
   parameter int TICK_M  = 1000000,
   parameter int N_TICKS = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] sw,
   output logic [N_CH-1:0] db,
   output logic [N_CH-1:0] ovr,
   input  logic            clr_ovr,
   debnc_evt_arb_if.master evt
);
   localparam int CHW = $clog2(N_CH);
   localparam int TCW = $clog2(TICK_M);
   localparam int WCW = (N_TICKS > 1) ? $clog2(N_TICKS) : 1;
   localparam logic [TCW-1:0] TC_LAST = TCW'(TICK_M - 1);
   localparam logic [WCW-1:0] WC_LAST = WCW'(N_TICKS - 1);
   localparam logic [CHW-1:0] CH_LAST = CHW'(N_CH - 1);

   typedef enum logic {IDLE, HOLD} state_t;

   logic [N_CH-1:0] sw_m, sws;
   logic [TCW-1:0]  tcnt;
   logic            m_tic;
   logic [WCW-1:0]  wc [N_CH];
   logic [N_CH-1:0] tog;
   logic [N_CH-1:0] rise_q;
   logic [N_CH-1:0] pend_r, clr_r;
   logic [N_CH-1:0] pend_any, sel_oh, ovr_set;
   logic [CHW-1:0]  ptr, sel_ch, ch_q;
   logic            sel_vld, take, done;
   state_t          state, state_nxt;
`ifdef DEBNC_FALL_EVT_EN
   logic [N_CH-1:0] fall_q, pend_f, clr_f;
   logic            sel_rise, rise_out;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         sw_m <= '0;
         sws  <= '0;
      end else begin
         sw_m <= sw;
         sws  <= sw_m;
      end
   end

   assign m_tic = (tcnt == TC_LAST);

   always_ff @(posedge clk) begin
      if (rst || m_tic) tcnt <= '0;
      else              tcnt <= tcnt + TCW'(1);
   end

   // A channel flips on the tick that completes N_TICKS ticks of disagreement.
   always_comb begin
      for (int i = 0; i < N_CH; i++)
         tog[i] = (sws[i] != db[i]) && m_tic && (wc[i] == WC_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         db     <= '0;
         rise_q <= '0;
         for (int i = 0; i < N_CH; i++) wc[i] <= '0;
      end else begin
         db     <= db ^ tog;
         rise_q <= tog & ~db;
         for (int i = 0; i < N_CH; i++) begin
            if (sws[i] == db[i] || tog[i]) wc[i] <= '0;
            else if (m_tic)                wc[i] <= wc[i] + WCW'(1);
         end
      end
   end

`ifdef DEBNC_FALL_EVT_EN
   always_ff @(posedge clk) begin
      if (rst) fall_q <= '0;
      else     fall_q <= tog & db;
   end
   assign pend_any = pend_r | pend_f;
`else
   assign pend_any = pend_r;
`endif

   // First pending channel at or after ptr, wrapping around.
   always_comb begin
      int idx;
      idx     = 0;
      sel_vld = 1'b0;
      sel_ch  = '0;
`ifdef DEBNC_FALL_EVT_EN
      sel_rise = 1'b1;
`endif
      for (int k = 0; k < N_CH; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N_CH) idx = idx - N_CH;
         if (!sel_vld && pend_any[idx]) begin
            sel_vld = 1'b1;
            sel_ch  = CHW'(idx);
`ifdef DEBNC_FALL_EVT_EN
            sel_rise = pend_r[idx];
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: if (sel_vld) begin
            state_nxt = HOLD;
            take      = 1'b1;
         end
         HOLD: if (evt.evt_ready) begin
            state_nxt = IDLE;
            done      = 1'b1;
         end
      endcase
   end

   assign sel_oh = take ? ({{(N_CH-1){1'b0}}, 1'b1} << sel_ch) : '0;

`ifdef DEBNC_FALL_EVT_EN
   assign clr_r   = sel_oh & {N_CH{sel_rise}};
   assign clr_f   = sel_oh & {N_CH{~sel_rise}};
   assign ovr_set = (rise_q & pend_r & ~clr_r) | (fall_q & pend_f & ~clr_f);

   always_ff @(posedge clk) begin
      if (rst) pend_f <= '0;
      else     pend_f <= (pend_f & ~clr_f) | fall_q;
   end
`else
   assign clr_r   = sel_oh;
   assign ovr_set = rise_q & pend_r & ~clr_r;
`endif

   // A new edge on a bit being consumed this cycle re-arms it (set wins).
   always_ff @(posedge clk) begin
      if (rst) begin
         pend_r <= '0;
         ovr    <= '0;
      end else begin
         pend_r <= (pend_r & ~clr_r) | rise_q;
         ovr    <= (clr_ovr ? '0 : ovr) | ovr_set;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ch_q <= '0;
         ptr  <= '0;
      end else begin
         if (take) ch_q <= sel_ch;
         if (done) ptr  <= (ch_q == CH_LAST) ? '0 : ch_q + CHW'(1);
      end
   end

`ifdef DEBNC_FALL_EVT_EN
   always_ff @(posedge clk) begin
      if (rst)       rise_out <= 1'b0;
      else if (take) rise_out <= sel_rise;
   end
   assign evt.evt_rise = rise_out;
`else
   assign evt.evt_rise = 1'b1;
`endif

   assign evt.evt_valid = (state == HOLD);
   assign evt.evt_ch    = ch_q;
endmodule

// File: tb/tb_debnc_evt_arb.sv
module tb_debnc_evt_arb;
   localparam int N_CH    = 4;
   localparam int TICK_M  = 4;
   localparam int N_TICKS = 3;
`ifdef DEBNC_FALL_EVT_EN
   localparam bit FALL_EN = 1'b1;
`else
   localparam bit FALL_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic [N_CH-1:0] sw;
   logic [N_CH-1:0] db, ovr;
   logic            clr_ovr;
   logic            evt_ready;

   debnc_evt_arb_if #(.N_CH(N_CH)) eif ();
   assign eif.evt_ready = evt_ready;

   debnc_evt_arb #(.N_CH(N_CH), .TICK_M(TICK_M), .N_TICKS(N_TICKS)) dut (
      .clk     (clk),
      .rst     (rst),
      .sw      (sw),
      .db      (db),
      .ovr     (ovr),
      .clr_ovr (clr_ovr),
      .evt     (eif)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural reference ----------------
   // Level path: sw seen two cycles late; a channel flips once N_TICKS ticks
   // (every TICK_M-th cycle since reset) have elapsed with the seen level
   // differing. Event path: an accepted edge becomes pending one cycle later;
   // an idle presenter grabs the first pending channel from ptr onwards.
   int  m_s1 [N_CH], m_s2 [N_CH], m_ticks [N_CH], m_db [N_CH];
   int  m_rq [N_CH], m_fq [N_CH], m_pr [N_CH], m_pf [N_CH], m_ov [N_CH];
   int  m_age, m_ptr, m_ch, m_rise;
   bit  m_busy, m_ok = 1'b0, m_tic;

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_CH; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_ticks[i] = 0; m_db[i] = 0;
            m_rq[i] = 0; m_fq[i] = 0; m_pr[i] = 0; m_pf[i] = 0; m_ov[i] = 0;
         end
         m_age = 0; m_ptr = 0; m_ch = 0; m_rise = 1; m_busy = 1'b0; m_ok = 1'b1;
      end else begin
         m_tic = (m_age % TICK_M) == (TICK_M - 1);
         m_age++;
         if (m_busy) begin
            if (evt_ready) begin
               m_busy = 1'b0;
               m_ptr  = (m_ch + 1) % N_CH;
            end
         end else begin
            for (int k = 0; k < N_CH; k++) begin
               int c;
               c = (m_ptr + k) % N_CH;
               if (!m_busy && (m_pr[c] != 0 || m_pf[c] != 0)) begin
                  m_busy = 1'b1;
                  m_ch   = c;
                  m_rise = m_pr[c];
                  if (m_pr[c] != 0) m_pr[c] = 0;
                  else              m_pf[c] = 0;
               end
            end
         end
         for (int i = 0; i < N_CH; i++) begin
            if (clr_ovr) m_ov[i] = 0;
            if (m_rq[i] != 0) begin
               if (m_pr[i] != 0) m_ov[i] = 1;
               m_pr[i] = 1;
            end
            if (FALL_EN && m_fq[i] != 0) begin
               if (m_pf[i] != 0) m_ov[i] = 1;
               m_pf[i] = 1;
            end
            m_rq[i] = 0; m_fq[i] = 0;
            if (m_s2[i] == m_db[i]) m_ticks[i] = 0;
            else if (m_tic) begin
               m_ticks[i]++;
               if (m_ticks[i] == N_TICKS) begin
                  m_ticks[i] = 0;
                  if (m_db[i] == 0) m_rq[i] = 1; else m_fq[i] = 1;
                  m_db[i] = 1 - m_db[i];
               end
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = int'(sw[i]);
         end
      end
   end

   function automatic int pack(input int a [N_CH]);
      int v;
      v = 0;
      for (int i = 0; i < N_CH; i++) if (a[i] != 0) v |= (1 << i);
      return v;
   endfunction

   // ---------------- checking ----------------
   int n_err = 0, n_chk = 0;
   int cyc = 0;
   int ev_ch [$];
   int ev_rise [$];
   int db0_rise_cyc = -100, vld_rise_cyc = -100;
   bit prev_db0 = 1'b0, prev_vld = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         if (n_err <= 40) $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, act, exp);
      end
   endtask

   // One clock: compare against the model mid-cycle, log handshakes, then
   // return just after the next rising edge where stimulus may change.
   task automatic tick();
      @(negedge clk);
      cyc++;
      if (m_ok) begin
         chk("db", int'(db), pack(m_db));
         chk("ovr", int'(ovr), pack(m_ov));
         chk("evt_valid", int'(eif.evt_valid), int'(m_busy));
         if (m_busy) begin
            chk("evt_ch", int'(eif.evt_ch), m_ch);
            chk("evt_rise", int'(eif.evt_rise), m_rise);
         end
      end
      if (eif.evt_valid && evt_ready) begin
         ev_ch.push_back(int'(eif.evt_ch));
         ev_rise.push_back(int'(eif.evt_rise));
      end
      if (db[0] && !prev_db0) db0_rise_cyc = cyc;
      if (eif.evt_valid && !prev_vld) vld_rise_cyc = cyc;
      prev_db0 = db[0];
      prev_vld = eif.evt_valid;
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pulse_rst();
      rst = 1'b1; tick(); rst = 1'b0;
   endtask

   int n0, k;

   initial begin
      rst = 1'b1; sw = '0; evt_ready = 1'b0; clr_ovr = 1'b0;
      run(3);
      chk("rst_valid", int'(eif.evt_valid), 0);
      chk("rst_db", int'(db), 0);
      chk("rst_ovr", int'(ovr), 0);
      chk("rst_ch", int'(eif.evt_ch), 0);

      // single debounced rise on ch0
      rst = 1'b0; evt_ready = 1'b1; sw = 4'b0001; n0 = ev_ch.size();
      run(20);
      chk("rise_db0", int'(db[0]), 1);
      chk("rise_count", ev_ch.size() - n0, 1);
      if (ev_ch.size() > n0) begin
         chk("rise_ch", ev_ch[n0], 0);
         chk("rise_dir", ev_rise[n0], 1);
      end
      chk("rise_latency", vld_rise_cyc - db0_rise_cyc, 2);

      // 6-cycle glitch on ch1
      n0 = ev_ch.size();
      sw = 4'b0011; run(6); sw = 4'b0001; run(25);
      chk("glitch_db1", int'(db[1]), 0);
      chk("glitch_events", ev_ch.size() - n0, 0);

      // simultaneous rises, then pointer wrap ordering
      sw = 4'b0000; pulse_rst();
      n0 = ev_ch.size();
      sw = 4'b1111; run(30);
      chk("rr_count", ev_ch.size() - n0, 4);
      for (int i = 0; i < 4; i++)
         if (ev_ch.size() > n0 + i) chk("rr_order", ev_ch[n0 + i], i);
      sw = 4'b1011; run(25);
      sw = 4'b1111; run(25);
      sw = 4'b0101; run(25);
      n0 = ev_ch.size();
      sw = 4'b1111; run(25);
      chk("wrap_count", ev_ch.size() - n0, 2);
      if (ev_ch.size() >= n0 + 2) begin
         chk("wrap_first", ev_ch[n0], 3);
         chk("wrap_second", ev_ch[n0 + 1], 1);
      end

      // overrun while the consumer stalls
      sw = 4'b0000; pulse_rst();
      evt_ready = 1'b0; n0 = ev_ch.size();
      sw = 4'b0100; run(25);
      sw = 4'b0000; run(25);
      sw = 4'b0100; run(25);
      sw = 4'b0000; run(25);
      sw = 4'b0100; run(25);
      chk("ovr_set", int'(ovr), 4);
      chk("ovr_hold_valid", int'(eif.evt_valid), 1);
      chk("ovr_hold_ch", int'(eif.evt_ch), 2);
      chk("ovr_hold_rise", int'(eif.evt_rise), 1);
      chk("ovr_no_accept", ev_ch.size() - n0, 0);
      clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;
      chk("ovr_clr", int'(ovr), 0);

      // reset while holding an event; switch still high afterwards
      rst = 1'b1; tick();
      chk("rsthold_valid", int'(eif.evt_valid), 0);
      chk("rsthold_db", int'(db), 0);
      chk("rsthold_ovr", int'(ovr), 0);
      rst = 1'b0; evt_ready = 1'b1; n0 = ev_ch.size();
      run(25);
      chk("postrst_count", ev_ch.size() - n0, 1);
      if (ev_ch.size() > n0) chk("postrst_ch", ev_ch[n0], 2);

      // falling edge on ch3
      sw = 4'b1100; run(25);
      n0 = ev_ch.size();
      sw = 4'b0100; run(25);
      chk("fall_db3", int'(db[3]), 0);
      chk("fall_count", ev_ch.size() - n0, FALL_EN ? 1 : 0);
      if (FALL_EN && ev_ch.size() > n0) begin
         chk("fall_ch", ev_ch[n0], 3);
         chk("fall_dir", ev_rise[n0], 0);
      end

      // randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 11) == 0) begin
            k = $urandom_range(0, N_CH - 1);
            sw[k] = ~sw[k];
         end
         evt_ready = ($urandom_range(0, 2) != 0);
         clr_ovr   = ($urandom_range(0, 39) == 0);
         rst       = ($urandom_range(0, 599) == 0);
         tick();
      end
      rst = 1'b0; clr_ovr = 1'b0; evt_ready = 1'b1;
      run(60);
      chk("drain_valid", int'(eif.evt_valid), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
